// File: rtl/alu_seq_param_if.sv
// Request/response bundle between the CPU datapath (master) and the sequential ALU (slave).
interface alu_seq_param_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [1:0]             op;
    logic [2*WIDTH-1:0]     result;
    logic                   busy;
    logic                   done;
    logic                   dz;
    logic                   ovf;
    logic [2:0]             state;

    modport master (
        output start, a, b, op,
        input  result, busy, done, dz, ovf, state
    );

    modport slave (
        input  start, a, b, op,
        output result, busy, done, dz, ovf, state
    );
endinterface

// File: rtl/alu_seq_param.sv
// Signed ADD/SUB/MUL(Booth)/DIV(restoring) ALU with start/busy/done handshake.
// Optional macro ALU_REM_EN packs {remainder, quotient} into the DIV result and enables ovf.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_seq_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_ADDSUB = 3'b001,
        S_MUL    = 3'b011,
        S_DIV    = 3'b100,
        S_DONE   = 3'b101
    } state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_a, r_b, r_q;
    logic [1:0]         r_op;
    logic [WIDTH:0]     r_acc;
    logic               r_qm1, r_init, r_busy, r_done, r_dz;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic               w_last;
    logic [WIDTH:0]     w_sum, w_mcand, w_mul_sum;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs;
    logic [WIDTH:0]     w_div_shift, w_div_diff, w_div_r_next;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_q_next;
    logic [WIDTH:0]     w_q_mag, w_q_signed;
    logic [2*WIDTH-1:0] w_addsub_result, w_dz_result, w_div_result;

    assign w_last = !r_init && (r_cnt == '0);

    // ADD/SUB in WIDTH+1 bits is always exact
    assign w_sum = (r_op == OP_SUB) ? ({r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b})
                                    : ({r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b});

    // Booth step; the extra accumulator bit keeps acc - (-2^(W-1)) from wrapping
    assign w_mcand = {r_a[WIDTH-1], r_a};
    always_comb begin
        w_mul_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_mul_sum = r_acc + w_mcand;
            2'b10:   w_mul_sum = r_acc - w_mcand;
            default: w_mul_sum = r_acc;
        endcase
    end

    // Restoring step on magnitudes; |min| still fits as an unsigned WIDTH-bit value
    assign w_a_abs      = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_b_abs      = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_div_shift  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_div_diff   = w_div_shift - {1'b0, w_b_abs};
    assign w_div_ge     = !w_div_diff[WIDTH];
    assign w_div_r_next = w_div_ge ? w_div_diff : w_div_shift;
    assign w_div_q_next = {r_q[WIDTH-2:0], w_div_ge};
    assign w_q_mag      = {1'b0, w_div_q_next};
    assign w_q_signed   = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_q_mag : w_q_mag;

`ifdef ALU_REM_EN
    logic [WIDTH-1:0] w_r_signed;
    logic             r_ovf;
    assign w_r_signed   = r_a[WIDTH-1] ? -w_div_r_next[WIDTH-1:0] : w_div_r_next[WIDTH-1:0];
    assign w_div_result = {w_r_signed, w_q_signed[WIDTH-1:0]};
    assign w_dz_result  = {r_a, {WIDTH{1'b1}}};
    assign bus.ovf      = r_ovf;
`else
    assign w_div_result = {{(WIDTH-1){w_q_signed[WIDTH]}}, w_q_signed};
    assign w_dz_result  = {(2*WIDTH){1'b1}};
    assign bus.ovf      = 1'b0;
`endif

    assign w_addsub_result = (r_op == OP_DIV) ? w_dz_result
                                              : {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL)
                        w_state_next = S_MUL;
                    else if (bus.op == OP_DIV && bus.b != '0)
                        w_state_next = S_DIV;
                    else
                        w_state_next = S_ADDSUB;
                end
            end
            S_ADDSUB:     w_state_next = S_DONE;
            S_MUL, S_DIV: if (w_last) w_state_next = S_DONE;
            S_DONE:       w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase
    end

    // The first MUL/DIV cycle loads working registers from the latched operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_op <= '0; r_q <= '0; r_acc <= '0;
            r_qm1 <= 1'b0; r_init <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
            r_dz <= 1'b0; r_cnt <= '0; r_result <= '0;
`ifdef ALU_REM_EN
            r_ovf <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_op   <= bus.op;
                        r_busy <= 1'b1;
                        r_dz   <= 1'b0;
                        r_init <= 1'b1;
`ifdef ALU_REM_EN
                        r_ovf  <= 1'b0;
`endif
                    end
                end
                S_ADDSUB: begin
                    r_result <= w_addsub_result;
                    r_dz     <= (r_op == OP_DIV);
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                S_MUL, S_DIV: begin
                    if (r_init) begin
                        r_acc  <= '0;
                        r_q    <= (r_state == S_MUL) ? r_b : w_a_abs;
                        r_qm1  <= 1'b0;
                        r_cnt  <= CW'(WIDTH - 1);
                        r_init <= 1'b0;
                    end else begin
                        if (r_state == S_MUL) begin
                            r_acc <= {w_mul_sum[WIDTH], w_mul_sum[WIDTH:1]};
                            r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                            r_qm1 <= r_q[0];
                        end else begin
                            r_acc <= w_div_r_next;
                            r_q   <= w_div_q_next;
                        end
                        if (w_last) begin
                            r_result <= (r_state == S_MUL) ? {w_mul_sum, r_q[WIDTH-1:1]}
                                                           : w_div_result;
`ifdef ALU_REM_EN
                            r_ovf    <= (r_state == S_DIV) &&
                                        (w_q_signed[WIDTH] != w_q_signed[WIDTH-1]);
`endif
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.dz     = r_dz;
    assign bus.state  = r_state;
endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param at WIDTH=8: directed ops, ignored start, reset abort.
module tb_alu_seq_param;
    localparam int W = 8;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        dz;
        logic        ovf;
        int          done_cyc;
    } exp_t;
    exp_t sb[$];

    alu_seq_param_if #(.WIDTH(W)) bus_if ();
    alu_seq_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus_if.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, 32'(bus_if.result), 32'(e.res));
                chk({e.name, "_dz"}, 32'(bus_if.dz), 32'(e.dz));
                chk({e.name, "_ovf"}, 32'(bus_if.ovf), 32'(e.ovf));
                chk({e.name, "_latency_cycle"}, 32'(cyc), 32'(e.done_cyc));
                $display("txn %s result=0x%04h dz=%0b ovf=%0b at cycle %0d",
                         e.name, bus_if.result, bus_if.dz, bus_if.ovf, cyc);
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_res, input logic exp_dz,
                          input logic exp_ovf, input int lat, input int poke);
        int c0;
        int n;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = op; bus_if.a = a; bus_if.b = b;
        c0 = cyc;
        sb.push_back('{name, exp_res, exp_dz, exp_ovf, c0 + lat});
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a = 8'($urandom); bus_if.b = 8'($urandom); bus_if.op = 2'($urandom);
        n = 0;
        while (bus_if.done !== 1'b1 && n < 40) begin
            chk({name, "_busy"}, 32'(bus_if.busy), 32'd1);
            if (cyc - c0 == poke) begin
                bus_if.start = 1'b1; bus_if.op = ADD;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus_if.start = 1'b0;
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(bus_if.busy), 32'd0);
        chk({name, "_idle_after"}, 32'(bus_if.state), 32'd0);
    endtask

    initial begin
        bus_if.start = 1'b0; bus_if.a = '0; bus_if.b = '0; bus_if.op = '0;
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", 32'(bus_if.state), 32'd0);
        chk("reset_result", 32'(bus_if.result), 32'd0);
        chk("reset_busy", 32'(bus_if.busy), 32'd0);
        chk("reset_done", 32'(bus_if.done), 32'd0);
        chk("reset_dz", 32'(bus_if.dz), 32'd0);
        chk("reset_ovf", 32'(bus_if.ovf), 32'd0);

        run_op("add_100_100", ADD, 8'd100, 8'd100, 16'h00C8, 1'b0, 1'b0, 2, -1);
        run_op("sub_m128_1", SUB, 8'h80, 8'd1, 16'hFF7F, 1'b0, 1'b0, 2, -1);
        run_op("add_3_m5", ADD, 8'd3, 8'hFB, 16'hFFFE, 1'b0, 1'b0, 2, -1);
        run_op("mul_m7_6", MUL, 8'hF9, 8'd6, 16'hFFD6, 1'b0, 1'b0, 10, -1);
        run_op("mul_m128_m128", MUL, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 10, -1);
        run_op("mul_127_m128", MUL, 8'd127, 8'h80, 16'hC080, 1'b0, 1'b0, 10, -1);
`ifdef ALU_REM_EN
        run_op("div_7_m2", DIV, 8'd7, 8'hFE, 16'h01FD, 1'b0, 1'b0, 10, -1);
        run_op("div_m7_2", DIV, 8'hF9, 8'd2, 16'hFFFD, 1'b0, 1'b0, 10, -1);
        run_op("div_100_7", DIV, 8'd100, 8'd7, 16'h020E, 1'b0, 1'b0, 10, -1);
        run_op("div_m128_m1", DIV, 8'h80, 8'hFF, 16'h0080, 1'b0, 1'b1, 10, -1);
        run_op("div_5_0", DIV, 8'd5, 8'd0, 16'h05FF, 1'b1, 1'b0, 2, -1);
`else
        run_op("div_7_m2", DIV, 8'd7, 8'hFE, 16'hFFFD, 1'b0, 1'b0, 10, -1);
        run_op("div_m7_2", DIV, 8'hF9, 8'd2, 16'hFFFD, 1'b0, 1'b0, 10, -1);
        run_op("div_100_7", DIV, 8'd100, 8'd7, 16'h000E, 1'b0, 1'b0, 10, -1);
        run_op("div_m128_m1", DIV, 8'h80, 8'hFF, 16'h0080, 1'b0, 1'b0, 10, -1);
        run_op("div_5_0", DIV, 8'd5, 8'd0, 16'hFFFF, 1'b1, 1'b0, 2, -1);
`endif
        run_op("add_clears_dz", ADD, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 2, -1);
        run_op("mul_start_ignored", MUL, 8'd5, 8'hFD, 16'hFFF1, 1'b0, 1'b0, 10, 3);

        // Abort a DIV with reset: no done pulse may follow
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = DIV; bus_if.a = 8'd100; bus_if.b = 8'd7;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", 32'(bus_if.state), 32'd0);
        chk("abort_result", 32'(bus_if.result), 32'd0);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_done", 32'(bus_if.done), 32'd0);
        repeat (12) @(negedge clk);
        run_op("add_after_abort", ADD, 8'd1, 8'd2, 16'h0003, 1'b0, 1'b0, 2, -1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
